// File: rtl/id_ex_if.sv
// ID/EX stage bundle: decoded instruction from ID on one side,
// registered EX copies plus the load-use stall request on the other.
interface id_ex_if #(
    parameter int bitnum  = 32,
    parameter int regbits = 5,
    parameter int cntbits = 16
);
    logic               id_valid;
    logic [bitnum-1:0]  id_pc4;
    logic [bitnum-1:0]  id_rs_data;
    logic [bitnum-1:0]  id_rt_data;
    logic [bitnum-1:0]  id_imm;
    logic [regbits-1:0] id_rs;
    logic [regbits-1:0] id_rt;
    logic [regbits-1:0] id_rd;
    logic               id_uses_rs;
    logic               id_uses_rt;
    logic               id_regwrite;
    logic               id_memtoreg;
    logic               id_memread;
    logic               id_memwrite;
    logic               id_alusrc;
    logic               id_regdst;
    logic [1:0]         id_aluop;
    logic               flush_ex;
    logic               hold;

    logic               ex_valid;
    logic [bitnum-1:0]  ex_pc4;
    logic [bitnum-1:0]  ex_rs_data;
    logic [bitnum-1:0]  ex_rt_data;
    logic [bitnum-1:0]  ex_imm;
    logic [regbits-1:0] ex_rs;
    logic [regbits-1:0] ex_rt;
    logic [regbits-1:0] ex_rd;
    logic               ex_regwrite;
    logic               ex_memtoreg;
    logic               ex_memread;
    logic               ex_memwrite;
    logic               ex_alusrc;
    logic               ex_regdst;
    logic [1:0]         ex_aluop;
    logic               stall_out;
    logic [cntbits-1:0] bubble_cnt;

    // Pipeline control side: drives ID fields, flush and hold
    modport master (
        output id_valid, id_pc4, id_rs_data, id_rt_data, id_imm,
               id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
               id_regwrite, id_memtoreg, id_memread, id_memwrite,
               id_alusrc, id_regdst, id_aluop, flush_ex, hold,
        input  ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memtoreg,
               ex_memread, ex_memwrite, ex_alusrc, ex_regdst,
               ex_aluop, stall_out, bubble_cnt
    );

    // The ID/EX register itself
    modport slave (
        input  id_valid, id_pc4, id_rs_data, id_rt_data, id_imm,
               id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
               id_regwrite, id_memtoreg, id_memread, id_memwrite,
               id_alusrc, id_regdst, id_aluop, flush_ex, hold,
        output ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memtoreg,
               ex_memread, ex_memwrite, ex_alusrc, ex_regdst,
               ex_aluop, stall_out, bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble
// insertion, branch flush, external hold and a saturating bubble counter.
module id_ex_stage #(
    parameter int bitnum  = 32,
    parameter int regbits = 5,
    parameter int cntbits = 16
) (
    input logic    clk,
    input logic    rst,
    id_ex_if.slave bus
);
    localparam logic [regbits-1:0] zero_reg = '0;
    localparam logic [cntbits-1:0] cnt_max  = '1;

    logic hazard;
    logic rs_match;
    logic rt_match;

    // Load in EX whose destination is read by the instruction in ID; $zero never counts
    always_comb begin
        rs_match = bus.id_uses_rs & (bus.id_rs == bus.ex_rt);
        rt_match = bus.id_uses_rt & (bus.id_rt == bus.ex_rt);
        hazard   = bus.ex_valid & bus.ex_memread & (bus.ex_rt != zero_reg)
                 & bus.id_valid & (rs_match | rt_match);
    end

    // A flush wins over the stall so the PC can take the redirect
    assign bus.stall_out = hazard & ~bus.flush_ex;

    // Pipeline register: flush > hold > hazard bubble > normal load
    always_ff @(posedge clk or posedge rst) begin
        if (rst || bus.flush_ex || (!bus.hold && hazard)) begin
            bus.ex_valid    <= 1'b0;
            bus.ex_pc4      <= {bitnum{1'b0}};
            bus.ex_rs_data  <= {bitnum{1'b0}};
            bus.ex_rt_data  <= {bitnum{1'b0}};
            bus.ex_imm      <= {bitnum{1'b0}};
            bus.ex_rs       <= zero_reg;
            bus.ex_rt       <= zero_reg;
            bus.ex_rd       <= zero_reg;
            bus.ex_regwrite <= 1'b0;
            bus.ex_memtoreg <= 1'b0;
            bus.ex_memread  <= 1'b0;
            bus.ex_memwrite <= 1'b0;
            bus.ex_alusrc   <= 1'b0;
            bus.ex_regdst   <= 1'b0;
            bus.ex_aluop    <= 2'b00;
        end else if (!bus.hold) begin
            bus.ex_valid    <= bus.id_valid;
            bus.ex_pc4      <= bus.id_pc4;
            bus.ex_rs_data  <= bus.id_rs_data;
            bus.ex_rt_data  <= bus.id_rt_data;
            bus.ex_imm      <= bus.id_imm;
            bus.ex_rs       <= bus.id_rs;
            bus.ex_rt       <= bus.id_rt;
            bus.ex_rd       <= bus.id_rd;
            bus.ex_regwrite <= bus.id_regwrite & bus.id_valid;
            bus.ex_memtoreg <= bus.id_memtoreg & bus.id_valid;
            bus.ex_memread  <= bus.id_memread  & bus.id_valid;
            bus.ex_memwrite <= bus.id_memwrite & bus.id_valid;
            bus.ex_alusrc   <= bus.id_alusrc   & bus.id_valid;
            bus.ex_regdst   <= bus.id_regdst   & bus.id_valid;
            bus.ex_aluop    <= bus.id_aluop;
        end
    end

    // Count inserted load-use bubbles, sticking at all ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.bubble_cnt <= '0;
        end else if (!bus.flush_ex && !bus.hold && hazard && (bus.bubble_cnt != cnt_max)) begin
            bus.bubble_cnt <= bus.bubble_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus random
// traffic compared against a behavioural model of the ID/EX register.
module tb_id_ex_stage;
    localparam int BN = 32;
    localparam int RB = 5;
    localparam int CB = 4;
    localparam int CNT_MAX = (1 << CB) - 1;

    typedef struct packed {
        logic          valid;
        logic [BN-1:0] pc4;
        logic [BN-1:0] rs_data;
        logic [BN-1:0] rt_data;
        logic [BN-1:0] imm;
        logic [RB-1:0] rs;
        logic [RB-1:0] rt;
        logic [RB-1:0] rd;
        logic          regwrite;
        logic          memtoreg;
        logic          memread;
        logic          memwrite;
        logic          alusrc;
        logic          regdst;
        logic [1:0]    aluop;
    } ex_t;

    typedef struct packed {
        logic          valid;
        logic [BN-1:0] pc4;
        logic [BN-1:0] rs_data;
        logic [BN-1:0] rt_data;
        logic [BN-1:0] imm;
        logic [RB-1:0] rs;
        logic [RB-1:0] rt;
        logic [RB-1:0] rd;
        logic          uses_rs;
        logic          uses_rt;
        logic          regwrite;
        logic          memtoreg;
        logic          memread;
        logic          memwrite;
        logic          alusrc;
        logic          regdst;
        logic [1:0]    aluop;
    } id_t;

    logic clk = 1'b0;
    logic rst;

    int   total = 0;
    int   bad   = 0;
    ex_t  model_ex;
    int   model_cnt;
    logic exp_stall;
    id_t  cur_id;
    bit   cur_fl;
    bit   cur_hd;

    always #5 clk = ~clk;

    id_ex_if #(.bitnum(BN), .regbits(RB), .cntbits(CB)) bus ();

    id_ex_stage #(.bitnum(BN), .regbits(RB), .cntbits(CB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic ex_t actual_ex();
        ex_t e;
        e.valid    = bus.ex_valid;
        e.pc4      = bus.ex_pc4;
        e.rs_data  = bus.ex_rs_data;
        e.rt_data  = bus.ex_rt_data;
        e.imm      = bus.ex_imm;
        e.rs       = bus.ex_rs;
        e.rt       = bus.ex_rt;
        e.rd       = bus.ex_rd;
        e.regwrite = bus.ex_regwrite;
        e.memtoreg = bus.ex_memtoreg;
        e.memread  = bus.ex_memread;
        e.memwrite = bus.ex_memwrite;
        e.alusrc   = bus.ex_alusrc;
        e.regdst   = bus.ex_regdst;
        e.aluop    = bus.ex_aluop;
        return e;
    endfunction

    // A real load in EX writing a nonzero register that ID actually reads
    function automatic bit model_hazard(ex_t e, id_t d);
        if (!(e.valid && e.memread) || e.rt == 0 || !d.valid) return 1'b0;
        return (d.uses_rs && d.rs == e.rt) || (d.uses_rt && d.rt == e.rt);
    endfunction

    function automatic ex_t from_id(id_t d);
        ex_t e;
        e.valid    = d.valid;
        e.pc4      = d.pc4;
        e.rs_data  = d.rs_data;
        e.rt_data  = d.rt_data;
        e.imm      = d.imm;
        e.rs       = d.rs;
        e.rt       = d.rt;
        e.rd       = d.rd;
        e.regwrite = d.regwrite & d.valid;
        e.memtoreg = d.memtoreg & d.valid;
        e.memread  = d.memread  & d.valid;
        e.memwrite = d.memwrite & d.valid;
        e.alusrc   = d.alusrc   & d.valid;
        e.regdst   = d.regdst   & d.valid;
        e.aluop    = d.aluop;
        return e;
    endfunction

    function automatic id_t rand_id();
        id_t d;
        d          = '0;
        d.valid    = ($urandom_range(0, 9) != 0);
        d.pc4      = $urandom;
        d.rs_data  = $urandom;
        d.rt_data  = $urandom;
        d.imm      = $urandom;
        d.rs       = RB'($urandom_range(0, 3));
        d.rt       = RB'($urandom_range(0, 3));
        d.rd       = RB'($urandom);
        d.uses_rs  = 1'($urandom);
        d.uses_rt  = 1'($urandom);
        d.regwrite = 1'($urandom);
        d.memtoreg = 1'($urandom);
        d.memread  = 1'($urandom);
        d.memwrite = 1'($urandom);
        d.alusrc   = 1'($urandom);
        d.regdst   = 1'($urandom);
        d.aluop    = 2'($urandom);
        return d;
    endfunction

    function automatic id_t make_lw(logic [RB-1:0] rt);
        id_t d;
        d          = rand_id();
        d.valid    = 1'b1;
        d.rt       = rt;
        d.memread  = 1'b1;
        d.memtoreg = 1'b1;
        d.regwrite = 1'b1;
        d.memwrite = 1'b0;
        d.uses_rs  = 1'b0;
        d.uses_rt  = 1'b0;
        return d;
    endfunction

    function automatic id_t make_dep(logic [RB-1:0] rs, bit urs, logic [RB-1:0] rt, bit urt);
        id_t d;
        d          = rand_id();
        d.valid    = 1'b1;
        d.rs       = rs;
        d.rt       = rt;
        d.uses_rs  = urs;
        d.uses_rt  = urt;
        d.memread  = 1'b0;
        return d;
    endfunction

    // Drive ID-side inputs and work out the expected stall for this cycle
    task automatic apply(input id_t d, input bit fl, input bit hd);
        cur_id = d;
        cur_fl = fl;
        cur_hd = hd;
        bus.id_valid    = d.valid;
        bus.id_pc4      = d.pc4;
        bus.id_rs_data  = d.rs_data;
        bus.id_rt_data  = d.rt_data;
        bus.id_imm      = d.imm;
        bus.id_rs       = d.rs;
        bus.id_rt       = d.rt;
        bus.id_rd       = d.rd;
        bus.id_uses_rs  = d.uses_rs;
        bus.id_uses_rt  = d.uses_rt;
        bus.id_regwrite = d.regwrite;
        bus.id_memtoreg = d.memtoreg;
        bus.id_memread  = d.memread;
        bus.id_memwrite = d.memwrite;
        bus.id_alusrc   = d.alusrc;
        bus.id_regdst   = d.regdst;
        bus.id_aluop    = d.aluop;
        bus.flush_ex    = fl;
        bus.hold        = hd;
        #1;
        exp_stall = model_hazard(model_ex, d) && !fl;
    endtask

    // Advance the model by the stage rules, then let the DUT take its edge
    task automatic clock_edge();
        if (cur_fl) begin
            model_ex = '0;
        end else if (cur_hd) begin
            model_ex = model_ex;
        end else if (model_hazard(model_ex, cur_id)) begin
            model_ex = '0;
            if (model_cnt < CNT_MAX) model_cnt = model_cnt + 1;
        end else begin
            model_ex = from_id(cur_id);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_ex  = '0;
        model_cnt = 0;
        #2;
        rst = 1'b0;
        apply('0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        id_t d;
        d = make_dep(5'd1, 1'b1, 5'd2, 1'b1);
        d.regwrite = 1'b1;
        apply(make_lw(5'd8), 1'b0, 1'b0);
        clock_edge();
        apply(make_dep(5'd8, 1'b1, 5'd0, 1'b0), 1'b0, 1'b0);
        clock_edge();
        apply(d, 1'b0, 1'b0);
        clock_edge();
        total++;
        if (bus.ex_regwrite !== 1'b1 || bus.bubble_cnt !== 4'd1) begin
            bad++;
            $display("[TB] FAIL reset_preload: regwrite=%b cnt=%0d want 1 and 1", bus.ex_regwrite, bus.bubble_cnt);
        end
        rst = 1'b1;
        model_ex  = '0;
        model_cnt = 0;
        #1;
        total++;
        if (actual_ex() !== ex_t'(0)) begin
            bad++;
            $display("[TB] FAIL reset_async_ex: got %h want 0", actual_ex());
        end
        total++;
        if (bus.bubble_cnt !== 4'd0) begin
            bad++;
            $display("[TB] FAIL reset_async_cnt: got %0d want 0", bus.bubble_cnt);
        end
        @(posedge clk);
        #1;
        total++;
        if (actual_ex() !== ex_t'(0) || bus.bubble_cnt !== 4'd0) begin
            bad++;
            $display("[TB] FAIL reset_held: got %h cnt %0d want 0", actual_ex(), bus.bubble_cnt);
        end
        rst = 1'b0;
        apply('0, 1'b0, 1'b0);
    endtask

    task automatic test_passthrough();
        id_t d;
        d          = make_dep(5'd3, 1'b1, 5'd4, 1'b1);
        d.rs_data  = 32'h1234_5678;
        d.imm      = 32'hFFFF_FFFC;
        d.rd       = 5'd9;
        d.regwrite = 1'b1;
        d.aluop    = 2'b10;
        apply(d, 1'b0, 1'b0);
        total++;
        if (bus.stall_out !== 1'b0) begin
            bad++;
            $display("[TB] FAIL pass_stall: got %b want 0", bus.stall_out);
        end
        clock_edge();
        total++;
        if (bus.ex_valid !== 1'b1 || bus.ex_rs_data !== 32'h1234_5678 || bus.ex_imm !== 32'hFFFF_FFFC
            || bus.ex_rd !== 5'd9 || bus.ex_regwrite !== 1'b1 || bus.ex_aluop !== 2'b10) begin
            bad++;
            $display("[TB] FAIL pass_fields: got v=%b rs=%h imm=%h rd=%0d rw=%b op=%b", bus.ex_valid,
                     bus.ex_rs_data, bus.ex_imm, bus.ex_rd, bus.ex_regwrite, bus.ex_aluop);
        end
        total++;
        if (actual_ex() !== model_ex) begin
            bad++;
            $display("[TB] FAIL pass_model: got %h want %h", actual_ex(), model_ex);
        end
        d       = rand_id();
        d.valid = 1'b0;
        d.regwrite = 1'b1;
        d.memread  = 1'b1;
        apply(d, 1'b0, 1'b0);
        clock_edge();
        total++;
        if (actual_ex() !== model_ex || bus.ex_regwrite !== 1'b0) begin
            bad++;
            $display("[TB] FAIL pass_invalid: got %h want %h", actual_ex(), model_ex);
        end
    endtask

    task automatic test_load_use();
        id_t dep;
        int  cnt0;
        cnt0 = model_cnt;
        dep  = make_dep(5'd8, 1'b1, 5'd5, 1'b0);
        apply(make_lw(5'd8), 1'b0, 1'b0);
        clock_edge();
        apply(dep, 1'b0, 1'b0);
        total++;
        if (bus.stall_out !== 1'b1) begin
            bad++;
            $display("[TB] FAIL loaduse_stall: got %b want 1", bus.stall_out);
        end
        clock_edge();
        total++;
        if (actual_ex() !== ex_t'(0) || 32'(bus.bubble_cnt) !== cnt0 + 1) begin
            bad++;
            $display("[TB] FAIL loaduse_bubble: got %h cnt %0d want 0 cnt %0d", actual_ex(), bus.bubble_cnt, cnt0 + 1);
        end
        apply(dep, 1'b0, 1'b0);
        total++;
        if (bus.stall_out !== 1'b0) begin
            bad++;
            $display("[TB] FAIL loaduse_release: got %b want 0", bus.stall_out);
        end
        clock_edge();
        total++;
        if (actual_ex() !== from_id(dep) || actual_ex() !== model_ex) begin
            bad++;
            $display("[TB] FAIL loaduse_advance: got %h want %h", actual_ex(), from_id(dep));
        end
    endtask

    task automatic test_no_false_hazard();
        apply(make_lw(5'd0), 1'b0, 1'b0);
        clock_edge();
        apply(make_dep(5'd0, 1'b1, 5'd0, 1'b1), 1'b0, 1'b0);
        total++;
        if (bus.stall_out !== 1'b0) begin
            bad++;
            $display("[TB] FAIL nofalse_zero: got %b want 0", bus.stall_out);
        end
        clock_edge();
        apply(make_lw(5'd8), 1'b0, 1'b0);
        clock_edge();
        apply(make_dep(5'd2, 1'b1, 5'd8, 1'b0), 1'b0, 1'b0);
        total++;
        if (bus.stall_out !== 1'b0) begin
            bad++;
            $display("[TB] FAIL nofalse_unused_rt: got %b want 0", bus.stall_out);
        end
        clock_edge();
        apply(make_lw(5'd6), 1'b0, 1'b0);
        clock_edge();
        apply(make_lw(5'd7), 1'b0, 1'b0);
        total++;
        if (bus.stall_out !== 1'b0) begin
            bad++;
            $display("[TB] FAIL nofalse_back_to_back: got %b want 0", bus.stall_out);
        end
        clock_edge();
        total++;
        if (actual_ex() !== model_ex) begin
            bad++;
            $display("[TB] FAIL nofalse_state: got %h want %h", actual_ex(), model_ex);
        end
    endtask

    task automatic test_priority();
        id_t dep;
        int  cnt0;
        dep = make_dep(5'd3, 1'b0, 5'd8, 1'b1);
        apply(make_lw(5'd8), 1'b0, 1'b0);
        clock_edge();
        cnt0 = model_cnt;
        apply(dep, 1'b1, 1'b0);
        total++;
        if (bus.stall_out !== 1'b0) begin
            bad++;
            $display("[TB] FAIL prio_flush_stall: got %b want 0", bus.stall_out);
        end
        clock_edge();
        total++;
        if (actual_ex() !== ex_t'(0) || 32'(bus.bubble_cnt) !== cnt0) begin
            bad++;
            $display("[TB] FAIL prio_flush_state: got %h cnt %0d want 0 cnt %0d", actual_ex(), bus.bubble_cnt, cnt0);
        end
        apply(make_lw(5'd8), 1'b0, 1'b0);
        clock_edge();
        apply(dep, 1'b0, 1'b1);
        total++;
        if (bus.stall_out !== 1'b1) begin
            bad++;
            $display("[TB] FAIL prio_hold_stall: got %b want 1", bus.stall_out);
        end
        clock_edge();
        total++;
        if (actual_ex() !== model_ex || bus.ex_memread !== 1'b1 || 32'(bus.bubble_cnt) !== cnt0) begin
            bad++;
            $display("[TB] FAIL prio_hold_state: got %h cnt %0d want %h cnt %0d", actual_ex(), bus.bubble_cnt, model_ex, cnt0);
        end
        apply(dep, 1'b0, 1'b0);
        clock_edge();
        total++;
        if (actual_ex() !== ex_t'(0) || 32'(bus.bubble_cnt) !== cnt0 + 1) begin
            bad++;
            $display("[TB] FAIL prio_after_hold: got %h cnt %0d want 0 cnt %0d", actual_ex(), bus.bubble_cnt, cnt0 + 1);
        end
    endtask

    task automatic test_reset_mid_stall();
        apply(make_lw(5'd4), 1'b0, 1'b0);
        clock_edge();
        apply(make_dep(5'd4, 1'b1, 5'd1, 1'b1), 1'b0, 1'b0);
        rst = 1'b1;
        model_ex  = '0;
        model_cnt = 0;
        #1;
        total++;
        if (bus.stall_out !== 1'b0 || bus.ex_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_mid_stall: stall=%b valid=%b want 0 0", bus.stall_out, bus.ex_valid);
        end
        rst = 1'b0;
        apply(cur_id, 1'b0, 1'b0);
        clock_edge();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            apply(make_lw(5'd9), 1'b0, 1'b0);
            clock_edge();
            apply(make_dep(5'd9, 1'b1, 5'd1, 1'b0), 1'b0, 1'b0);
            clock_edge();
        end
        total++;
        if (bus.bubble_cnt !== 4'hF || model_cnt != CNT_MAX) begin
            bad++;
            $display("[TB] FAIL saturate: got %0d want 15", bus.bubble_cnt);
        end
    endtask

    task automatic test_random();
        id_t d;
        for (int i = 0; i < 300; i++) begin
            d = rand_id();
            apply(d, ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0));
            total++;
            if (bus.stall_out !== exp_stall) begin
                bad++;
                $display("[TB] FAIL rand_stall[%0d]: got %b want %b", i, bus.stall_out, exp_stall);
            end
            clock_edge();
            total++;
            if (actual_ex() !== model_ex) begin
                bad++;
                $display("[TB] FAIL rand_state[%0d]: got %h want %h", i, actual_ex(), model_ex);
            end
            total++;
            if (32'(bus.bubble_cnt) !== model_cnt) begin
                bad++;
                $display("[TB] FAIL rand_cnt[%0d]: got %0d want %0d", i, bus.bubble_cnt, model_cnt);
            end
        end
    endtask

    // Scenario sequence
    initial begin
        rst       = 1'b1;
        model_ex  = '0;
        model_cnt = 0;
        apply('0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        total++;
        if (actual_ex() !== ex_t'(0) || bus.bubble_cnt !== 4'd0 || bus.stall_out !== 1'b0) begin
            bad++;
            $display("[TB] FAIL initial_reset: got %h cnt %0d stall %b", actual_ex(), bus.bubble_cnt, bus.stall_out);
        end
        rst = 1'b0;
        apply('0, 1'b0, 1'b0);
        test_reset();
        test_passthrough();
        test_load_use();
        test_no_false_hazard();
        test_priority();
        test_reset_mid_stall();
        test_saturation();
        do_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
